// File: rtl/mio_pkg.sv
// Shared types and constants for the memory-mapped I/O interconnect.
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mio_state_e;

  // Internal register window offsets, selected by a[3:2]
  localparam logic [1:0] REG_ERR_CNT  = 2'd0;
  localparam logic [1:0] REG_ERR_ADDR = 2'd1;
  localparam logic [1:0] REG_NCH      = 2'd2;
  localparam logic [1:0] REG_RSVD     = 2'd3;

  localparam int CH_VGA   = 0;
  localparam int CH_KBD   = 1;
  localparam int CH_SEG   = 2;
  localparam int CH_SPARE = 3;

endpackage

// File: rtl/mio_addr_dec.sv
// Address decoder: channel field, internal-window flag, out-of-range channel error.
// Purely combinational, no latency and no backpressure.
module mio_addr_dec #(
  parameter int NCH     = 4,
  parameter int SEL_LSB = 12,
  parameter int CW      = $clog2(NCH)
) (
  input  logic [31:0]   a,
  output logic [CW-1:0] ch,
  output logic          is_internal,
  output logic          dec_err
);

  logic unused_a;

  assign ch          = a[SEL_LSB +: CW];
  assign is_internal = a[SEL_LSB + CW];
  // Only reachable when NCH is not a power of two
  assign dec_err     = !is_internal && (int'(ch) >= NCH);
  assign unused_a    = ^a;

endmodule

// File: rtl/mio_bus_ctrl.sv
// Registered CPU-to-peripheral interconnect with req/ack handshake, slave timeout and status window.
// Latency 1 cycle (internal/decode error), 2+ cycles (slave); requests while busy are dropped.
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DW      = 32,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_a,
  input  logic [DW-1:0]     cpu_wd,
  output logic [DW-1:0]     cpu_rd,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic              busy,
  output logic [NCH-1:0]    s_sel,
  output logic              s_we,
  output logic [31:0]       s_a,
  output logic [DW-1:0]     s_wd,
  input  logic [NCH*DW-1:0] s_rd,
  input  logic [NCH-1:0]    s_ack
);

  localparam int CW = $clog2(NCH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  mio_state_e state_q, state_d;

  logic [CW-1:0]    dec_ch, ch_q;
  logic             dec_int, dec_err;
  logic [TW-1:0]    tmo_q;
  logic [CNT_W-1:0] err_cnt;
  logic [31:0]      err_addr;
  logic             err_q;
  logic             accept, slv_ack, tmo_hit, err_inc;
  logic [DW-1:0]    int_rd, slv_rd;

  mio_addr_dec #(
    .NCH     (NCH),
    .SEL_LSB (SEL_LSB),
    .CW      (CW)
  ) u_dec (
    .a           (cpu_a),
    .ch          (dec_ch),
    .is_internal (dec_int),
    .dec_err     (dec_err)
  );

  assign slv_rd  = s_rd[int'(ch_q)*DW +: DW];
  assign busy    = (state_q != IDLE);
  assign cpu_err = cpu_ack & err_q;
  assign err_inc = (accept & dec_err) | tmo_hit;

  always_comb begin
    int_rd = '0;
    case (cpu_a[3:2])
      REG_ERR_CNT:  int_rd = DW'(err_cnt);
      REG_ERR_ADDR: int_rd = DW'(err_addr);
      REG_NCH:      int_rd = DW'(8'(NCH));
      default:      int_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    slv_ack = 1'b0;
    tmo_hit = 1'b0;
    cpu_ack = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          accept  = 1'b1;
          state_d = (dec_int || dec_err) ? RESP : WAIT;
        end
      end
      WAIT: begin
        // A slave ack in the final counted cycle beats the timeout
        slv_ack = s_ack[ch_q];
        tmo_hit = !s_ack[ch_q] && (tmo_q == TMO_LAST);
        if (slv_ack || tmo_hit) state_d = RESP;
      end
      RESP: begin
        cpu_ack = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_sel  <= '0;
      s_we   <= 1'b0;
      s_a    <= '0;
      s_wd   <= '0;
      cpu_rd <= '0;
      ch_q   <= '0;
      tmo_q  <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      s_we  <= cpu_we;
      s_a   <= cpu_a;
      s_wd  <= cpu_wd;
      ch_q  <= dec_ch;
      tmo_q <= '0;
      err_q <= dec_err;
      if (dec_int) begin
        if (!cpu_we) cpu_rd <= int_rd;
      end else if (dec_err) begin
        cpu_rd <= '0;
      end else begin
        s_sel <= {{(NCH-1){1'b0}}, 1'b1} << dec_ch;
      end
    end else if (slv_ack) begin
      s_sel <= '0;
      if (!s_we) cpu_rd <= slv_rd;
    end else if (tmo_hit) begin
      s_sel  <= '0;
      err_q  <= 1'b1;
      cpu_rd <= '0;
    end else if (state_q == WAIT) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt  <= '0;
      err_addr <= '0;
    end else if (err_inc) begin
      if (!(&err_cnt)) err_cnt <= err_cnt + 1'b1;
      err_addr <= tmo_hit ? s_a : cpu_a;
    end else if (accept && dec_int && cpu_we && (cpu_a[3:2] == REG_ERR_CNT)) begin
      err_cnt <= '0;
    end
  end

endmodule

// File: doc/mio_bus_ctrl.md
Name: mio_bus_ctrl

Overview:
- Parametrised, registered memory-mapped I/O interconnect between the single-cycle CPU data port and NCH peripheral channels (VGA text RAM, PS/2 keyboard, seven-seg, spare).
- Replaces the fixed combinational CPU/VGA/keyboard read mux.
- Adds address decode, a per-transaction request/acknowledge handshake, a slave timeout and an internal status/error register window.

Parameters:
- NCH, 4, number of peripheral channels (2..8).
- DW, 32, data width of CPU and slave buses.
- SEL_LSB, 12, lowest address bit of the channel-select field.
- TIMEOUT, 16, cycles to wait for slave ack before error (>=2).
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  one-cycle transaction request; sampled only when busy=0.
- cpu_we  in  1  1=write, 0=read; sampled with cpu_req.
- cpu_a  in  32  byte address; sampled with cpu_req.
- cpu_wd  in  DW  write data; sampled with cpu_req.
- cpu_rd  out  DW  read data; valid when cpu_ack=1, held until the next response.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_err  out  1  qualifies cpu_ack: decode error or timeout.
- busy  out  1  high from the cycle after an accepted req until the cycle after cpu_ack.
- s_sel  out  NCH  one-hot channel select, held for the whole slave access.
- s_we  out  1  registered copy of cpu_we.
- s_a  out  32  registered copy of cpu_a.
- s_wd  out  DW  registered copy of cpu_wd.
- s_rd  in  NCH*DW  flattened slave read data; channel k occupies [k*DW +: DW].
- s_ack  in  NCH  per-channel acknowledge; only the selected channel's bit is honoured.

Behaviour:
- CW = clog2(NCH).
- Decode:
  - ch = a[SEL_LSB +: CW].
  - Internal window when a[SEL_LSB+CW]=1.
  - Decode error when ch >= NCH (non-power-of-two NCH).
- FSM states: IDLE, WAIT, RESP.
- IDLE, on cpu_req:
  - Latch we/a/wd into s_we/s_a/s_wd.
  - Internal access -> RESP.
  - Decode error -> RESP with err set.
  - Otherwise set s_sel[ch], clear the timeout counter, go to WAIT.
- WAIT:
  - s_sel[ch], s_a, s_wd and s_we stay stable.
  - If s_ack[ch]=1: capture s_rd slice ch into cpu_rd (reads only; writes leave cpu_rd unchanged), clear s_sel, go to RESP.
  - Else increment the counter. When the counter reaches TIMEOUT-1 without ack: clear s_sel, set err, cpu_rd=0, go to RESP.
  - An ack in the same cycle the counter hits TIMEOUT-1 wins; no error.
- RESP: cpu_ack=1 and cpu_err=err for exactly one cycle, then IDLE.
- Latency:
  - Internal and decode-error accesses: cpu_ack one cycle after cpu_req.
  - Slave acking in its first WAIT cycle: cpu_ack two cycles after cpu_req.
  - Timeout: cpu_ack TIMEOUT+1 cycles after cpu_req.
- cpu_req while busy=1 is ignored; no queueing.
- s_ack on non-selected channels, or in IDLE/RESP, is ignored.
- Internal window registers (offset = a[3:2]):
  - 0: err_cnt, zero-extended. Any write clears it.
  - 1: err_addr, the address of the last errored transaction. Read-only.
  - 2: {24'h0, NCH[7:0]}. Read-only.
  - 3: reads 0.
  - Writes to read-only offsets are dropped and still acked without error.
- Every decode error or timeout increments err_cnt, saturating at all-ones, and loads err_addr.
- Reset (any state, including mid-WAIT) forces IDLE with:
  - s_sel=0, cpu_ack=0, cpu_err=0, busy=0.
  - cpu_rd=0, s_a=0, s_wd=0, s_we=0.
  - err_cnt=0, err_addr=0.
  - No ack is ever issued for an aborted transaction.

Decomposition:
- Shared package mio_pkg:
  - FSM state encoding (IDLE/WAIT/RESP).
  - Internal register offset constants.
  - Default channel map: CH_VGA=0, CH_KBD=1, CH_SEG=2, CH_SPARE=3.
- One natural sub-module: mio_addr_dec. Purely combinational; produces ch, is_internal and dec_err from an address. Reusable by the instruction-side decoder.

Test Plan:
- Read ch1 (cpu_a=32'h0000_1004), slave1 acks in its first WAIT cycle with s_rd slice 32'h0000_01A5 -> s_sel=4'b0010 for one cycle; cpu_ack two cycles after req; cpu_rd=32'h0000_01A5; cpu_err=0.
- Write ch0 (cpu_a=32'h0000_0010, cpu_wd=32'h41), slave0 acks after 3 WAIT cycles -> s_wd=32'h41 and s_sel=4'b0001 held 3 cycles; cpu_ack=1, cpu_err=0; cpu_rd unchanged.
- Read ch2 with no ack, TIMEOUT=16 -> cpu_ack 17 cycles after req; cpu_err=1, cpu_rd=0. Internal reads then return err_cnt=1 and err_addr=32'h0000_2000.
- NCH=3 build, access ch3 (cpu_a=32'h0000_3000) -> cpu_ack next cycle with cpu_err=1; s_sel stays 0; err_cnt increments.
- Assert rst in the 2nd WAIT cycle of a ch1 read -> s_sel=0 and busy=0 next cycle; no cpu_ack. Then write internal offset 0 (32'h0000_4000) -> err_cnt reads 0.
- cpu_req pulsed again while busy, plus a spurious s_ack[3] during a ch1 wait -> second req ignored; only the ch1 ack completes the transaction.
